// File: rtl/serial_rx_fifo.sv
// Oversampling asynchronous serial receiver with configurable frame format,
// buffering decoded words in a show-ahead FIFO with sticky error flags.
module serial_rx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        m_clock,
  input  logic                        p_reset,
  input  logic                        rxd,
  input  logic                        port_read,
  input  logic                        err_clr,
  output logic [DATA_BITS-1:0]        data,
  output logic                        rxready,
  output logic                        done,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(CLK_DIV);
  localparam int BW   = $clog2(DATA_BITS);
  localparam logic [CW-1:0]   HALF     = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0]   LAST     = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] FULL     = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic b);
    logic ones_odd;
    ones_odd = (^d) ^ b;
    return (PARITY == 1) ? ~ones_odd : ones_odd;
  endfunction

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bit_idx, bit_nxt;
  logic                 shift_en, par_chk, stop_chk;
  logic                 bad_par;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxd_p0, rxs, rxs_prev;

  // Stage: synchroniser; rxs_prev exists only for falling-edge detection
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      rxd_p0   <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rxd_p0   <= rxd;
      rxs      <= rxd_p0;
      rxs_prev <= rxs;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    bit_nxt   = bit_idx;
    shift_en  = 1'b0;
    par_chk   = 1'b0;
    stop_chk  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (rxs_prev && !rxs) state_nxt = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_nxt = '0;
          bit_nxt = '0;
          state_nxt = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nxt  = '0;
          shift_en = 1'b1;
          bit_nxt  = bit_idx + BW'(1);
          if (bit_idx == LAST_BIT) state_nxt = (PARITY != 0) ? PAR : STOP;
        end
      end
      PAR: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          stop_chk  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage: frame decode
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      bad_par <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      if (state == IDLE)  bad_par <= 1'b0;
      else if (par_chk)   bad_par <= parity_bad(shreg, rxs);
    end
  end

  always_ff @(posedge m_clock) begin
    if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] last_head;
  logic                 push, pop, full, wr_en;

  assign push    = stop_chk & rxs;
  assign rxready = (count != '0);
  assign pop     = port_read & rxready;
  assign full    = (count == FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en   = push & (~full | pop);
  assign data    = rxready ? mem[rd_ptr] : last_head;

  // Stage: FIFO write / pop
  always_ff @(posedge m_clock) begin
    if (wr_en) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_head  <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        last_head <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      done       <= wr_en;
      frame_err  <= (stop_chk & ~rxs)        | (frame_err  & ~err_clr);
      parity_err <= (push & bad_par)         | (parity_err & ~err_clr);
      overrun    <= (push & full & ~pop)     | (overrun    & ~err_clr);
    end
  end

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo: an 8N1 instance and an 8E1 instance,
// with a FIFO-content scoreboard per instance.
module tb_serial_rx_fifo;
  localparam int DIV = 16;

  logic       m_clock = 1'b0;
  logic       p_reset;
  logic       rxd_a, rxd_b, rd_a, rd_b, clr_a, clr_b;
  logic [7:0] data_a, data_b;
  logic       rdy_a, rdy_b, done_a, done_b;
  logic [4:0] cnt_a;
  logic [2:0] cnt_b;
  logic       fe_a, pe_a, ov_a, fe_b, pe_b, ov_b;

  int tests = 0;
  int fails = 0;
  int nd_a = 0;
  int nd_b = 0;
  int base;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  serial_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_a (
    .m_clock(m_clock), .p_reset(p_reset), .rxd(rxd_a), .port_read(rd_a), .err_clr(clr_a),
    .data(data_a), .rxready(rdy_a), .done(done_a), .count(cnt_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

  serial_rx_fifo #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .m_clock(m_clock), .p_reset(p_reset), .rxd(rxd_b), .port_read(rd_b), .err_clr(clr_b),
    .data(data_b), .rxready(rdy_b), .done(done_b), .count(cnt_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

  always #5 m_clock = ~m_clock;

  always @(negedge m_clock) begin
    if (done_a) nd_a++;
    if (done_b) nd_b++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge m_clock);
    #1;
  endtask

  // One bit period on the selected line; optional pop in the push cycle of the stop bit
  task automatic drive_bit(input bit sel, input logic v, input bit pop_mid);
    for (int i = 0; i < DIV; i++) begin
      if (sel) rxd_b = v;
      else     rxd_a = v;
      rd_a = pop_mid && (i == 11);
      @(posedge m_clock);
      #1;
    end
  endtask

  task automatic send(input bit sel, input logic [7:0] w, input logic par_bit,
                      input logic stop_bit, input bit pop_at_push);
    drive_bit(sel, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(sel, w[k], 1'b0);
    if (sel) drive_bit(sel, par_bit, 1'b0);
    drive_bit(sel, stop_bit, pop_at_push);
    if (sel) rxd_b = 1'b1;
    else     rxd_a = 1'b1;
    tick(4);
  endtask

  task automatic pop(input bit sel, input string tag);
    logic [7:0] e;
    if (sel) begin
      e = exp_b.pop_front();
      chk(tag, 32'(data_b), 32'(e));
      rd_b = 1'b1; tick(1); rd_b = 1'b0;
    end else begin
      e = exp_a.pop_front();
      chk(tag, 32'(data_a), 32'(e));
      rd_a = 1'b1; tick(1); rd_a = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] drop;
    p_reset = 1'b0;
    rxd_a = 1'b1; rxd_b = 1'b1;
    rd_a = 1'b0; rd_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    tick(3);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_rxready", 32'(rdy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_data", 32'(data_a), 0);
    chk("rst_flags_a", {29'd0, fe_a, pe_a, ov_a}, 0);
    chk("rst_flags_b", {28'd0, rdy_b, fe_b, pe_b, ov_b}, 0);
    p_reset = 1'b1;
    tick(3);

    // basic 8N1 word
    base = nd_a;
    send(0, 8'h41, 1'b0, 1'b1, 0);
    exp_a.push_back(8'h41);
    chk("t1_done", nd_a - base, 1);
    chk("t1_data", 32'(data_a), 32'(exp_a[0]));
    chk("t1_rxready", 32'(rdy_a), 1);
    chk("t1_count", 32'(cnt_a), exp_a.size());
    pop(0, "t1_pop");
    chk("t1_count_after", 32'(cnt_a), 0);
    chk("t1_rxready_after", 32'(rdy_a), 0);
    chk("t1_last_head", 32'(data_a), 32'h41);

    // short glitch is rejected
    base = nd_a;
    rxd_a = 1'b0; tick(5); rxd_a = 1'b1; tick(40);
    chk("t2_glitch_done", nd_a - base, 0);
    chk("t2_glitch_count", 32'(cnt_a), 0);
    send(0, 8'h55, 1'b0, 1'b1, 0);
    exp_a.push_back(8'h55);
    chk("t2_done", nd_a - base, 1);
    chk("t2_count", 32'(cnt_a), exp_a.size());
    pop(0, "t2_pop");

    // even parity: 0x03 with wrong parity bit 1, then 0x07 with correct bit 1
    base = nd_b;
    send(1, 8'h03, 1'b1, 1'b1, 0);
    exp_b.push_back(8'h03);
    chk("t3_parity_err", 32'(pe_b), 1);
    chk("t3_data", 32'(data_b), 32'h03);
    chk("t3_count", 32'(cnt_b), exp_b.size());
    chk("t3_done", nd_b - base, 1);
    clr_b = 1'b1; tick(1); clr_b = 1'b0;
    chk("t3_parity_clr", 32'(pe_b), 0);
    send(1, 8'h07, 1'b1, 1'b1, 0);
    exp_b.push_back(8'h07);
    chk("t3_good_parity", 32'(pe_b), 0);
    chk("t3_count2", 32'(cnt_b), exp_b.size());
    pop(1, "t3_pop0");
    pop(1, "t3_pop1");

    // framing error drops the word
    base = nd_a;
    send(0, 8'h7E, 1'b0, 1'b0, 0);
    chk("t4_frame_err", 32'(fe_a), 1);
    chk("t4_count", 32'(cnt_a), 0);
    chk("t4_done", nd_a - base, 0);
    send(0, 8'h20, 1'b0, 1'b1, 0);
    exp_a.push_back(8'h20);
    chk("t4_next_count", 32'(cnt_a), exp_a.size());
    chk("t4_next_data", 32'(data_a), 32'h20);
    chk("t4_frame_sticky", 32'(fe_a), 1);
    clr_a = 1'b1; tick(1); clr_a = 1'b0;
    chk("t4_frame_clr", 32'(fe_a), 0);
    pop(0, "t4_pop");

    // overrun, then simultaneous push and pop on a full FIFO
    base = nd_a;
    for (int v = 0; v <= 16; v++) begin
      w = 8'(v);
      send(0, w, 1'b0, 1'b1, 0);
      if (v < 16) exp_a.push_back(w);
    end
    chk("t5_count_full", 32'(cnt_a), 16);
    chk("t5_overrun", 32'(ov_a), 1);
    chk("t5_head", 32'(data_a), 32'h00);
    chk("t5_done", nd_a - base, 16);
    chk("t5_head_pre", 32'(data_a), 32'(exp_a[0]));
    drop = exp_a.pop_front();
    base = nd_a;
    send(0, 8'h11, 1'b0, 1'b1, 1);
    exp_a.push_back(8'h11);
    chk("t5_popped_word", 32'(drop), 32'h00);
    chk("t5_count_same", 32'(cnt_a), exp_a.size());
    chk("t5_push_done", nd_a - base, 1);
    for (int i = 0; i < 16; i++) pop(0, "t5_drain");
    chk("t5_count_empty", 32'(cnt_a), 0);

    // reset in the middle of a 0xA5 frame, released during the high last data bit
    base = nd_a;
    w = 8'hA5;
    drive_bit(0, 1'b0, 0);
    for (int k = 0; k < 3; k++) drive_bit(0, w[k], 0);
    p_reset = 1'b0;
    tick(1);
    chk("t6_rst_count", 32'(cnt_a), 0);
    chk("t6_rst_overrun", 32'(ov_a), 0);
    for (int k = 3; k < 7; k++) drive_bit(0, w[k], 0);
    p_reset = 1'b1;
    drive_bit(0, w[7], 0);
    drive_bit(0, 1'b1, 0);
    tick(40);
    chk("t6_no_done", nd_a - base, 0);
    chk("t6_count", 32'(cnt_a), 0);
    send(0, 8'h5A, 1'b0, 1'b1, 0);
    exp_a.push_back(8'h5A);
    chk("t6_next_done", nd_a - base, 1);
    chk("t6_next_count", 32'(cnt_a), exp_a.size());
    pop(0, "t6_pop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
